// File: rtl/jtpang_objdma.sv
// Object DMA: requests the Z80 bus, then copies 2^AW bytes from the CPU video bus
// into the object buffer, two cen cycles per byte, holding off while the bus is stolen.
module jtpang_objdma #(
    parameter int          AW       = 9,
    parameter logic [11:0] SRC_BASE = 12'h000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          dma_go,
    output logic          busrq_n,
    input  logic          busak_n,
    output logic          busy,
    output logic          done,
    output logic [11:0]   src_addr,
    output logic          src_rd,
    input  logic [7:0]    src_dout,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          obj_we
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        REL  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   obj_addr_q, obj_addr_d;
    logic [7:0]      obj_din_q, obj_din_d;
    logic            obj_we_q, obj_we_d;
    logic            done_q, done_d;
    logic            pend_q, pend_d;
    logic            go_q, go_d;
    logic            start;

    assign start = cen & dma_go & ~go_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        obj_addr_d = obj_addr_q;
        obj_din_d  = obj_din_q;
        obj_we_d   = 1'b0;
        done_d     = 1'b0;
        pend_d     = pend_q;
        go_d       = cen ? dma_go : go_q;

        if (start && state_q != IDLE) begin
            pend_d = 1'b1;
        end

        if (cen) begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = REQ;
                end
                REQ: begin
                    if (!busak_n) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                    end
                end
                ADDR: begin
                    if (!busak_n) state_d = DATA;
                end
                DATA: begin
                    // A withdrawn acknowledge freezes the byte in flight until the bus returns
                    if (!busak_n) begin
                        obj_din_d  = src_dout;
                        obj_addr_d = cnt_q;
                        obj_we_d   = 1'b1;
                        if (cnt_q == LAST) begin
                            state_d = REL;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ADDR;
                        end
                    end
                end
                REL: begin
                    // A request landing on this same cycle still counts as pending
                    state_d = (pend_q || start) ? REQ : IDLE;
                    pend_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            obj_addr_q <= '0;
            obj_din_q  <= '0;
            obj_we_q   <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            obj_addr_q <= obj_addr_d;
            obj_din_q  <= obj_din_d;
            obj_we_q   <= obj_we_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            go_q       <= go_d;
        end
    end

    assign busrq_n  = !(state_q == REQ || state_q == ADDR || state_q == DATA);
    assign busy     = (state_q != IDLE);
    assign src_rd   = (state_q == ADDR);
    assign src_addr = SRC_BASE + 12'(cnt_q);
    assign obj_addr = obj_addr_q;
    assign obj_din  = obj_din_q;
    assign obj_we   = obj_we_q;
    assign done     = done_q;

endmodule
